// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single-port RAM between the core-side interface and
// the JTAG loader. The core wins by default. JTAG writes queue in a small FIFO
// and drain into idle cycles. Starvation, a full FIFO or a halted core force a
// drain.
module ram_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [3:0]    core_wen,
    input  logic          core_ren,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic [DW-1:0] core_rdata,
    output logic          core_busy,
    input  logic          jtag_we,
    input  logic [AW-1:0] jtag_addr,
    input  logic [DW-1:0] jtag_wdata,
    input  logic          halt_i,
    output logic          jtag_full,
    output logic          jtag_ovf,
    output logic [3:0]    ram_wen,
    output logic          ram_ren,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [PW:0]   DEPTH_C  = (PW+1)'(FIFO_DEPTH);
    localparam logic [SW-1:0] STARVE_C = SW'(STARVE_MAX);

    // FIFO storage (data only, never reset) and control state
    logic [AW-1:0] fifo_addr [FIFO_DEPTH];
    logic [DW-1:0] fifo_data [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic [SW-1:0] starve_cnt;
    logic          ovf;

    logic core_req;
    logic jtag_pend;
    logic fifo_full;
    logic grant_jtag;
    logic grant_core;
    logic pop;
    logic push_ok;

    // Grant decision; everything is gated by rstn so outputs read 0 in reset
    always_comb begin
        core_req   = core_ren | (|core_wen);
        jtag_pend  = (count != '0);
        fifo_full  = (count == DEPTH_C);
        grant_jtag = rstn & jtag_pend &
                     (halt_i | ~core_req | (starve_cnt == STARVE_C) | fifo_full);
        grant_core = rstn & core_req & ~grant_jtag;
        pop        = grant_jtag;
        // A full FIFO always pops in the same cycle, so a push then still fits
        push_ok    = rstn & jtag_we & (~fifo_full | pop);
    end

    // FIFO payload write at the tail
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_addr[wr_ptr] <= jtag_addr;
            fifo_data[wr_ptr] <= jtag_wdata;
        end
    end

    // Pointers, occupancy, starvation counter and sticky overflow flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            ovf        <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (push_ok && !pop) begin
                count <= count + (PW+1)'(1);
            end else if (pop && !push_ok) begin
                count <= count - (PW+1)'(1);
            end
            if (grant_jtag || !jtag_pend) begin
                starve_cnt <= '0;
            end else if (grant_core && (starve_cnt != STARVE_C)) begin
                starve_cnt <= starve_cnt + SW'(1);
            end
            if (jtag_we && !push_ok) begin
                ovf <= 1'b1;
            end
        end
    end

    // RAM port mux and core-side status
    always_comb begin
        ram_wen   = 4'h0;
        ram_ren   = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (grant_jtag) begin
            ram_wen   = 4'hF;
            ram_addr  = fifo_addr[rd_ptr];
            ram_wdata = fifo_data[rd_ptr];
        end else if (grant_core) begin
            ram_wen   = core_wen;
            ram_ren   = core_ren;
            ram_addr  = core_addr;
            ram_wdata = core_wdata;
        end
        core_busy  = rstn & core_req & ~grant_core;
        core_rdata = rstn ? ram_rdata : '0;
        jtag_full  = rstn & fifo_full;
        jtag_ovf   = ovf;
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: constant vector table, directed multi-cycle
// sequences and randomized traffic against a queue-based reference model.
module tb_ram_arbiter;

    localparam int DEPTH = 4;
    localparam int SMAX  = 8;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [3:0]  core_wen = 4'h0;
    logic        core_ren = 1'b0;
    logic [31:0] core_addr = 32'h0;
    logic [31:0] core_wdata = 32'h0;
    logic [31:0] core_rdata;
    logic        core_busy;
    logic        jtag_we = 1'b0;
    logic [31:0] jtag_addr = 32'h0;
    logic [31:0] jtag_wdata = 32'h0;
    logic        halt_i = 1'b0;
    logic        jtag_full;
    logic        jtag_ovf;
    logic [3:0]  ram_wen;
    logic        ram_ren;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = 32'h0;

    int n_cmp = 0;
    int n_bad = 0;

    ram_arbiter #(.AW(32), .DW(32), .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rstn(rstn),
        .core_wen(core_wen), .core_ren(core_ren), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_rdata(core_rdata), .core_busy(core_busy),
        .jtag_we(jtag_we), .jtag_addr(jtag_addr), .jtag_wdata(jtag_wdata),
        .halt_i(halt_i), .jtag_full(jtag_full), .jtag_ovf(jtag_ovf),
        .ram_wen(ram_wen), .ram_ren(ram_ren), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural RAM with one-cycle read latency, plus a log of full-word writes
    typedef struct packed { logic [31:0] a; logic [31:0] d; } ent_t;
    logic [31:0] ram_mem [256];
    logic [31:0] ref_mem [256];
    ent_t        wr_log [$];
    logic [31:0] ram_tmp;

    always @(posedge clk) begin
        if (ram_ren) ram_rdata <= ram_mem[ram_addr[9:2]];
        if (|ram_wen) begin
            ram_tmp = ram_mem[ram_addr[9:2]];
            for (int b = 0; b < 4; b++)
                if (ram_wen[b]) ram_tmp[8*b +: 8] = ram_wdata[8*b +: 8];
            ram_mem[ram_addr[9:2]] <= ram_tmp;
        end
        if (rstn && ram_wen == 4'hF) wr_log.push_back({ram_addr, ram_wdata});
    end

    // Reference model: a queue of pending JTAG words and a starvation tally
    ent_t        q [$];
    int          m_starve = 0;
    logic        m_ovf = 1'b0;
    logic        m_rd_valid = 1'b0;
    logic [31:0] m_rdata = 32'h0;

    function automatic void decide(output logic gj, output logic gc);
        logic pend, req;
        pend = (q.size() > 0);
        req  = core_ren || (core_wen != 4'h0);
        gj   = pend && (halt_i || !req || m_starve == SMAX || q.size() == DEPTH);
        gc   = req && !gj;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q.delete();
            m_starve   = 0;
            m_ovf      = 1'b0;
            m_rd_valid = 1'b0;
        end else begin
            logic gj, gc, pend;
            int   sz;
            decide(gj, gc);
            pend = (q.size() > 0);
            sz   = q.size();
            m_rd_valid = gc && core_ren;
            if (gc && core_ren) m_rdata = ref_mem[core_addr[9:2]];
            if (gc)
                for (int b = 0; b < 4; b++)
                    if (core_wen[b]) ref_mem[core_addr[9:2]][8*b +: 8] = core_wdata[8*b +: 8];
            if (gj) begin
                ref_mem[q[0].a[9:2]] = q[0].d;
                void'(q.pop_front());
            end
            if (gj || !pend) m_starve = 0;
            else if (gc && m_starve < SMAX) m_starve++;
            if (jtag_we) begin
                if (sz < DEPTH || gj) q.push_back({jtag_addr, jtag_wdata});
                else m_ovf = 1'b1;
            end
        end
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare all outputs with the model at the current (settled) point
    task automatic check_model();
        logic gj, gc, req;
        logic [3:0]  ew;
        logic        er;
        logic [31:0] ea, ed;
        decide(gj, gc);
        req = core_ren || (core_wen != 4'h0);
        ew = 4'h0; er = 1'b0; ea = 32'h0; ed = 32'h0;
        if (gj) begin
            ew = 4'hF; ea = q[0].a; ed = q[0].d;
        end else if (gc) begin
            ew = core_wen; er = core_ren; ea = core_addr; ed = core_wdata;
        end
        cmp("m_ram_wen", 32'(ram_wen), 32'(ew));
        cmp("m_ram_ren", 32'(ram_ren), 32'(er));
        cmp("m_ram_addr", ram_addr, ea);
        cmp("m_ram_wdata", ram_wdata, ed);
        cmp("m_core_busy", 32'(core_busy), 32'(req && !gc));
        cmp("m_jtag_full", 32'(jtag_full), 32'(q.size() == DEPTH));
        cmp("m_jtag_ovf", 32'(jtag_ovf), 32'(m_ovf));
        if (m_rd_valid) cmp("m_core_rdata", core_rdata, m_rdata);
    endtask

    task automatic sample();
        @(negedge clk);
        check_model();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        core_wen = 4'h0; core_ren = 1'b0; core_addr = 32'h0; core_wdata = 32'h0;
        jtag_we = 1'b0; jtag_addr = 32'h0; jtag_wdata = 32'h0; halt_i = 1'b0;
    endtask

    typedef struct {
        logic ren; logic [3:0] wen; logic [31:0] ca; logic [31:0] cd;
        logic jw; logic [31:0] ja; logic [31:0] jd; logic halt;
        logic ebusy; logic [3:0] ewen; logic eren; logic [31:0] eaddr; logic [31:0] ewd;
        logic efull; logic chk_rd; logic [31:0] erd;
    } vec_t;
    vec_t tbl [13];

    int cnt, nj;
    logic seen_busy, done;
    logic [31:0] pa [5];
    logic [31:0] pd [5];

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = 32'hC0DE0000 ^ (32'(i) * 32'h01010101);
            ref_mem[i] = ram_mem[i];
        end
        ram_mem[64] = 32'h12345678;
        ref_mem[64] = 32'h12345678;

        //        ren   wen   core_addr   core_wdata    jw    jtag_addr  jtag_wdata    halt  busy  ewen  eren  eaddr       ewdata        full  chkrd erd
        tbl[0]  = '{1'b0, 4'h0, 32'h0,     32'h0,        1'b0, 32'h0,     32'h0,        1'b0, 1'b0, 4'h0, 1'b0, 32'h0,      32'h0,        1'b0, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 4'h0, 32'h100,   32'h0,        1'b0, 32'h0,     32'h0,        1'b0, 1'b0, 4'h0, 1'b1, 32'h100,    32'h0,        1'b0, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 4'h0, 32'h0,     32'h0,        1'b1, 32'h40,    32'hDEADBEEF, 1'b0, 1'b0, 4'h0, 1'b0, 32'h0,      32'h0,        1'b0, 1'b1, 32'h12345678};
        tbl[3]  = '{1'b0, 4'h0, 32'h0,     32'h0,        1'b0, 32'h0,     32'h0,        1'b0, 1'b0, 4'hF, 1'b0, 32'h40,     32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
        tbl[4]  = '{1'b0, 4'h0, 32'h0,     32'h0,        1'b0, 32'h0,     32'h0,        1'b0, 1'b0, 4'h0, 1'b0, 32'h0,      32'h0,        1'b0, 1'b0, 32'h0};
        tbl[5]  = '{1'b0, 4'h3, 32'h80,    32'hA5A5A5A5, 1'b0, 32'h0,     32'h0,        1'b0, 1'b0, 4'h3, 1'b0, 32'h80,     32'hA5A5A5A5, 1'b0, 1'b0, 32'h0};
        tbl[6]  = '{1'b1, 4'h0, 32'h40,    32'h0,        1'b0, 32'h0,     32'h0,        1'b0, 1'b0, 4'h0, 1'b1, 32'h40,     32'h0,        1'b0, 1'b0, 32'h0};
        tbl[7]  = '{1'b0, 4'h0, 32'h0,     32'h0,        1'b0, 32'h0,     32'h0,        1'b0, 1'b0, 4'h0, 1'b0, 32'h0,      32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
        tbl[8]  = '{1'b1, 4'h0, 32'h100,   32'h0,        1'b1, 32'h44,    32'h11,       1'b0, 1'b0, 4'h0, 1'b1, 32'h100,    32'h0,        1'b0, 1'b0, 32'h0};
        tbl[9]  = '{1'b1, 4'h0, 32'h104,   32'h0,        1'b0, 32'h0,     32'h0,        1'b0, 1'b0, 4'h0, 1'b1, 32'h104,    32'h0,        1'b0, 1'b1, 32'h12345678};
        tbl[10] = '{1'b1, 4'h0, 32'h108,   32'h0,        1'b0, 32'h0,     32'h0,        1'b1, 1'b1, 4'hF, 1'b0, 32'h44,     32'h11,       1'b0, 1'b0, 32'h0};
        tbl[11] = '{1'b1, 4'h0, 32'h108,   32'h0,        1'b0, 32'h0,     32'h0,        1'b1, 1'b0, 4'h0, 1'b1, 32'h108,    32'h0,        1'b0, 1'b0, 32'h0};
        tbl[12] = '{1'b0, 4'h0, 32'h0,     32'h0,        1'b0, 32'h0,     32'h0,        1'b0, 1'b0, 4'h0, 1'b0, 32'h0,      32'h0,        1'b0, 1'b0, 32'h0};

        // Reset with an active core request: every output must read 0
        idle_inputs();
        core_ren = 1'b1; core_addr = 32'h100;
        repeat (2) @(posedge clk);
        #3;
        cmp("rst_ram_ren", 32'(ram_ren), 32'h0);
        cmp("rst_ram_addr", ram_addr, 32'h0);
        cmp("rst_core_busy", 32'(core_busy), 32'h0);
        cmp("rst_jtag_full", 32'(jtag_full), 32'h0);
        cmp("rst_jtag_ovf", 32'(jtag_ovf), 32'h0);
        cmp("rst_core_rdata", core_rdata, 32'h0);
        @(posedge clk);
        #2 rstn = 1'b1;
        idle_inputs();

        // Constant vector table
        for (int i = 0; i < 13; i++) begin
            core_ren = tbl[i].ren; core_wen = tbl[i].wen;
            core_addr = tbl[i].ca; core_wdata = tbl[i].cd;
            jtag_we = tbl[i].jw; jtag_addr = tbl[i].ja; jtag_wdata = tbl[i].jd;
            halt_i = tbl[i].halt;
            @(negedge clk);
            cmp($sformatf("v%0d_busy", i), 32'(core_busy), 32'(tbl[i].ebusy));
            cmp($sformatf("v%0d_ram_wen", i), 32'(ram_wen), 32'(tbl[i].ewen));
            cmp($sformatf("v%0d_ram_ren", i), 32'(ram_ren), 32'(tbl[i].eren));
            cmp($sformatf("v%0d_ram_addr", i), ram_addr, tbl[i].eaddr);
            cmp($sformatf("v%0d_ram_wdata", i), ram_wdata, tbl[i].ewd);
            cmp($sformatf("v%0d_full", i), 32'(jtag_full), 32'(tbl[i].efull));
            if (tbl[i].chk_rd) cmp($sformatf("v%0d_rdata", i), core_rdata, tbl[i].erd);
            advance();
        end
        idle_inputs();
        repeat (2) begin sample(); advance(); end

        // Starvation: one pushed word waits exactly SMAX core grants
        core_ren = 1'b1; core_addr = 32'h10;
        jtag_we = 1'b1; jtag_addr = 32'h300; jtag_wdata = 32'h5A5A0001;
        sample(); advance();
        jtag_we = 1'b0;
        cnt = 0; seen_busy = 1'b0; done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            core_addr = 32'h10 + 32'(4 * k);
            sample();
            if (ram_wen == 4'hF) begin
                seen_busy = core_busy; done = 1'b1;
            end else if (ram_ren) cnt++;
            advance();
        end
        cmp("starve_core_grants", 32'(cnt), 32'(SMAX));
        cmp("starve_jtag_busy", 32'(seen_busy), 32'h1);
        idle_inputs();
        repeat (2) begin sample(); advance(); end

        // Five back-to-back pushes under continuous core reads
        wr_log.delete();
        core_ren = 1'b1;
        for (int k = 0; k < 5; k++) begin
            pa[k] = 32'h200 + 32'(4 * k);
            pd[k] = 32'hB0000000 + 32'(k);
            jtag_we = 1'b1; jtag_addr = pa[k]; jtag_wdata = pd[k];
            core_addr = 32'h20 + 32'(4 * k);
            sample();
            if (k == 4) cmp("full_after_4", 32'(jtag_full), 32'h1);
            advance();
        end
        jtag_we = 1'b0;
        for (int k = 0; k < 60; k++) begin
            core_addr = 32'h40 + 32'(4 * (k % 32));
            sample(); advance();
        end
        cmp("full_ovf", 32'(jtag_ovf), 32'h0);
        cmp("full_drained", 32'(jtag_full), 32'h0);
        cmp("full_log_size", 32'(wr_log.size()), 32'h5);
        for (int k = 0; k < 5; k++) begin
            if (k < wr_log.size()) begin
                cmp($sformatf("order_addr%0d", k), wr_log[k].a, pa[k]);
                cmp($sformatf("order_data%0d", k), wr_log[k].d, pd[k]);
            end
        end
        idle_inputs();
        repeat (2) begin sample(); advance(); end

        // Halt drain: four queued words, core keeps requesting
        core_ren = 1'b1; core_addr = 32'h60;
        for (int k = 0; k < 4; k++) begin
            jtag_we = 1'b1; jtag_addr = 32'h280 + 32'(4 * k); jtag_wdata = 32'hC0000000 + 32'(k);
            sample(); advance();
        end
        jtag_we = 1'b0; halt_i = 1'b1;
        nj = 0; done = 1'b0;
        for (int k = 0; k < 10 && !done; k++) begin
            sample();
            if (ram_wen == 4'hF && core_busy) nj++;
            else begin
                cmp("halt_core_after_ren", 32'(ram_ren), 32'h1);
                cmp("halt_core_after_busy", 32'(core_busy), 32'h0);
                done = 1'b1;
            end
            advance();
        end
        cmp("halt_jtag_run", 32'(nj), 32'h4);
        cmp("halt_core_granted", 32'(done), 32'h1);
        idle_inputs();
        repeat (2) begin sample(); advance(); end

        // Asynchronous reset mid-drain discards the FIFO
        core_ren = 1'b1; core_addr = 32'h70;
        for (int k = 0; k < 2; k++) begin
            jtag_we = 1'b1; jtag_addr = 32'h2C0 + 32'(4 * k); jtag_wdata = 32'hD0000000 + 32'(k);
            sample(); advance();
        end
        jtag_we = 1'b0;
        #2 rstn = 1'b0;
        #1;
        cmp("mid_rst_ram_wen", 32'(ram_wen), 32'h0);
        cmp("mid_rst_ram_ren", 32'(ram_ren), 32'h0);
        cmp("mid_rst_ram_addr", ram_addr, 32'h0);
        cmp("mid_rst_ram_wdata", ram_wdata, 32'h0);
        cmp("mid_rst_busy", 32'(core_busy), 32'h0);
        cmp("mid_rst_rdata", core_rdata, 32'h0);
        @(posedge clk);
        #2 rstn = 1'b1;
        idle_inputs();
        sample();
        cmp("post_rst_ram_wen", 32'(ram_wen), 32'h0);
        cmp("post_rst_busy", 32'(core_busy), 32'h0);
        advance();

        // Randomized traffic; a stalled core holds its request
        seen_busy = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (!seen_busy) begin
                core_ren = ($urandom_range(0, 1) == 1);
                core_wen = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'h0;
                core_addr = {22'h0, 8'($urandom), 2'b00};
                core_wdata = $urandom;
            end
            jtag_we = ($urandom_range(0, 9) < 3);
            jtag_addr = {22'h0, 8'($urandom), 2'b00};
            jtag_wdata = $urandom;
            halt_i = ($urandom_range(0, 9) == 0);
            sample();
            seen_busy = core_busy;
            advance();
        end
        idle_inputs();
        repeat (12) begin sample(); advance(); end
        for (int i = 0; i < 256; i += 17)
            cmp($sformatf("mem_%0d", i), ram_mem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
